// File: rtl/pipelined_processor.sv
// pipelined_processor
//   Five-stage in-order 32-bit MIPS-style core (IF, ID, EX, MEM, WB) with a
//   unified word-addressed instruction/data memory and a 32x32 register file.
//   The core runs from PC 0 after reset until HLT retires.
//
// Ports
//   clk     in   single clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   halted  out  high once HLT has retired (mirrors HALTED)
//
// Hierarchically visible state: Reg[0:31], Mem[0:MEM_DEPTH-1], PC, HALTED.
// Reg and Mem are never reset; they keep preloaded contents.
//
// Build option: define PROC_MUL_EN to enable the MUL instruction. Without it,
// MUL decodes as a NOP and no multiplier is built.

module pipelined_processor #(
  parameter int MEM_DEPTH = 1024
) (
  input  logic clk,
  input  logic rst_n,
  output logic halted
);

  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MUL
  } alu_op_e;

  // Decoded control; an all-zero value is a bubble.
  typedef struct packed {
    logic    reg_we;
    logic    is_load;
    logic    is_store;
    logic    is_br;
    logic    br_nez;
    logic    is_hlt;
    logic    use_imm;
    alu_op_e alu_op;
  } ctl_t;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] ir;
  } ifid_t;

  typedef struct packed {
    ctl_t        ctl;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
  } idex_t;

  typedef struct packed {
    logic        reg_we;
    logic        is_load;
    logic        is_store;
    logic        is_hlt;
    logic [31:0] res;
    logic [31:0] sdata;
    logic [4:0]  dst;
  } exmem_t;

  typedef struct packed {
    logic        reg_we;
    logic        is_hlt;
    logic [31:0] res;
    logic [4:0]  dst;
  } memwb_t;

  // Architectural state
  logic [31:0] Mem [0:MEM_DEPTH-1];
  logic [31:0] Reg [0:31];
  logic [31:0] PC, pc_d;
  logic        HALTED, halted_d;

  // Pipeline state
  logic   stop_q, stop_d;   // HLT has passed ID: fetch frozen for good
  ifid_t  ifid_q, ifid_d;
  idex_t  idex_q, idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;

  function automatic ctl_t decode(input logic [5:0] op);
    ctl_t c;
    c = '0;
    case (op)
      OP_ADD:   begin c.reg_we = 1'b1; c.alu_op = ALU_ADD; end
      OP_SUB:   begin c.reg_we = 1'b1; c.alu_op = ALU_SUB; end
      OP_AND:   begin c.reg_we = 1'b1; c.alu_op = ALU_AND; end
      OP_OR:    begin c.reg_we = 1'b1; c.alu_op = ALU_OR;  end
      OP_SLT:   begin c.reg_we = 1'b1; c.alu_op = ALU_SLT; end
      OP_MUL:   begin
`ifdef PROC_MUL_EN
        c.reg_we = 1'b1; c.alu_op = ALU_MUL;
`endif
      end
      OP_LW:    begin c.reg_we = 1'b1; c.is_load = 1'b1; c.use_imm = 1'b1; end
      OP_SW:    begin c.is_store = 1'b1; c.use_imm = 1'b1; end
      OP_ADDI:  begin c.reg_we = 1'b1; c.use_imm = 1'b1; c.alu_op = ALU_ADD; end
      OP_SUBI:  begin c.reg_we = 1'b1; c.use_imm = 1'b1; c.alu_op = ALU_SUB; end
      OP_SLTI:  begin c.reg_we = 1'b1; c.use_imm = 1'b1; c.alu_op = ALU_SLT; end
      OP_BNEQZ: begin c.is_br = 1'b1; c.br_nez = 1'b1; end
      OP_BEQZ:  begin c.is_br = 1'b1; end
      OP_HLT:   begin c.is_hlt = 1'b1; end
      default:  ;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLT: r = {31'b0, ($signed(a) < $signed(b))};
`ifdef PROC_MUL_EN
      ALU_MUL: r = a * b;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  // Register read with write-through from the WB stage.
  function automatic logic [31:0] rf_read(input logic [4:0] idx, input logic [31:0] v,
                                          input memwb_t w);
    if (idx == 5'd0) return '0;
    if (w.reg_we && w.dst == idx) return w.res;
    return v;
  endfunction

  // EX operand bypass. EX/MEM is younger so it is checked first; a load in
  // EX/MEM has no data yet, so its consumer sees the older value.
  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] v,
                                      input exmem_t m, input memwb_t w);
    if (idx == 5'd0) return '0;
    if (m.reg_we && !m.is_load && m.dst == idx) return m.res;
    if (w.reg_we && w.dst == idx) return w.res;
    return v;
  endfunction

  // ID
  logic [4:0]  id_rs, id_rt, id_rd, id_dst;
  logic [31:0] id_imm;
  ctl_t        id_ctl;
  logic        id_hlt;

  always_comb begin
    id_rs  = ifid_q.ir[25:21];
    id_rt  = ifid_q.ir[20:16];
    id_rd  = ifid_q.ir[15:11];
    id_imm = {{16{ifid_q.ir[15]}}, ifid_q.ir[15:0]};
    id_ctl = ifid_q.vld ? decode(ifid_q.ir[31:26]) : '0;
    id_dst = id_ctl.use_imm ? id_rt : id_rd;
    // Writes to R0 are dropped here so R0 never appears as a bypass source.
    if (id_dst == 5'd0) id_ctl.reg_we = 1'b0;
    id_hlt = id_ctl.is_hlt;
  end

  // EX
  logic [31:0] ex_a, ex_rt, ex_opb, ex_res, br_target;
  logic        br_taken;

  always_comb begin
    ex_a      = fwd(idex_q.rs, idex_q.a, exmem_q, memwb_q);
    ex_rt     = fwd(idex_q.rt, idex_q.b, exmem_q, memwb_q);
    ex_opb    = idex_q.ctl.use_imm ? idex_q.imm : ex_rt;
    ex_res    = alu(idex_q.ctl.alu_op, ex_a, ex_opb);
    br_taken  = idex_q.ctl.is_br && (idex_q.ctl.br_nez ? (ex_a != '0) : (ex_a == '0));
    br_target = idex_q.pc + 32'd1 + idex_q.imm;
  end

  // MEM
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic [31:0]   if_ir;

  always_comb begin
    mem_addr  = exmem_q.res[AW-1:0];
    mem_rdata = Mem[mem_addr];
    if_ir     = Mem[PC[AW-1:0]];
  end

  // Next-state for PC and pipeline registers
  always_comb begin
    stop_d   = stop_q | (id_hlt & ~br_taken);
    halted_d = HALTED | memwb_q.is_hlt;

    // Taken branch has priority: it also flushes an HLT sitting in ID.
    if (br_taken)              pc_d = br_target;
    else if (stop_q || id_hlt) pc_d = PC;
    else                       pc_d = PC + 32'd1;

    if (br_taken || stop_q || id_hlt) ifid_d = '0;
    else                              ifid_d = '{vld: 1'b1, pc: PC, ir: if_ir};

    if (br_taken) idex_d = '0;
    else begin
      idex_d     = '0;
      idex_d.ctl = id_ctl;
      idex_d.pc  = ifid_q.pc;
      idex_d.a   = rf_read(id_rs, Reg[id_rs], memwb_q);
      idex_d.b   = rf_read(id_rt, Reg[id_rt], memwb_q);
      idex_d.imm = id_imm;
      idex_d.rs  = id_rs;
      idex_d.rt  = id_rt;
      idex_d.dst = id_dst;
    end

    exmem_d.reg_we   = idex_q.ctl.reg_we;
    exmem_d.is_load  = idex_q.ctl.is_load;
    exmem_d.is_store = idex_q.ctl.is_store;
    exmem_d.is_hlt   = idex_q.ctl.is_hlt;
    exmem_d.res      = ex_res;
    exmem_d.sdata    = ex_rt;
    exmem_d.dst      = idex_q.dst;

    memwb_d.reg_we = exmem_q.reg_we;
    memwb_d.is_hlt = exmem_q.is_hlt;
    memwb_d.res    = exmem_q.is_load ? mem_rdata : exmem_q.res;
    memwb_d.dst    = exmem_q.dst;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC      <= '0;
      HALTED  <= 1'b0;
      stop_q  <= 1'b0;
      ifid_q  <= '0;
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      PC      <= pc_d;
      HALTED  <= halted_d;
      stop_q  <= stop_d;
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  // Architectural writes; no reset so preloaded contents survive.
  always_ff @(posedge clk) begin
    if (exmem_q.is_store) Mem[mem_addr] <= exmem_q.sdata;
    if (memwb_q.reg_we)   Reg[memwb_q.dst] <= memwb_q.res;
  end

  assign halted = HALTED;

endmodule

// File: tb/tb_pipelined_processor.sv
// tb_pipelined_processor
//   Directed programs for pipelined_processor. Each test preloads Reg/Mem while
//   reset is held, queues the expected architectural results, then releases
//   reset. A monitor waits for halted, then pops the queue and compares.

module tb_pipelined_processor;

  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_AND = 6'b000010;
  localparam logic [5:0] OP_OR  = 6'b000011, OP_SLT = 6'b000100, OP_MUL = 6'b000101;
  localparam logic [5:0] OP_LW  = 6'b001000, OP_SW  = 6'b001001, OP_ADDI = 6'b001010;
  localparam logic [5:0] OP_SUBI = 6'b001011, OP_SLTI = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101, OP_BEQZ = 6'b001110, OP_HLT = 6'b111111;
  localparam int BUDGET = 200;

  logic clk;
  logic rst_n;
  logic halted;

  pipelined_processor #(.MEM_DEPTH(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    int          kind;   // 0 = Reg, 1 = Mem, 2 = halt cycle
    int          idx;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   armed = 0;
  bit   done  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%08h) want %0d (0x%08h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic logic [31:0] r_t(input logic [5:0] op, input int rd, input int rs,
                                      input int rt);
    return {op, rs[4:0], rt[4:0], rd[4:0], 11'b0};
  endfunction

  function automatic logic [31:0] i_t(input logic [5:0] op, input int rt, input int rs,
                                      input int imm);
    return {op, rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic void exp_push(input string nm, input int kind, input int idx,
                                   input logic [31:0] v);
    sbq.push_back('{nm, kind, idx, v});
  endfunction

  // Preload: Reg[k]=k, memory cleared.
  task automatic preload();
    for (int k = 0; k < 32; k++) dut.Reg[k] = k;
    for (int k = 0; k < 1024; k++) dut.Mem[k] = 32'd0;
  endtask

  // Release reset just after an edge so the next edge is the first fetch,
  // wait for the monitor, then reset asynchronously and check it took effect.
  task automatic run(input string nm);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc   = 0;
    done  = 0;
    armed = 1;
    wait (done);
    #3;
    rst_n = 1'b0;
    #1;
    chk({nm, "_rst_halted"}, {31'b0, halted}, 32'd0);
    chk({nm, "_rst_pc"}, dut.PC, 32'd0);
  endtask

  // Monitor: counts edges since release, compares the queue once halted.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (armed) begin
        cyc++;
        #1;
        if (halted || cyc >= BUDGET) begin
          chk("halted", {31'b0, halted}, 32'd1);
          while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.kind)
              0:       chk(e.nm, dut.Reg[e.idx], e.exp);
              1:       chk(e.nm, dut.Mem[e.idx], e.exp);
              default: chk(e.nm, cyc, e.exp);
            endcase
          end
          armed = 0;
          done  = 1;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", dut.PC, 32'd0);
    chk("reset_halted", {31'b0, halted}, 32'd0);

    // Load with forwarding and store data bypass
    preload();
    dut.Mem[120] = 32'd85;
    dut.Mem[0] = i_t(OP_ADDI, 1, 0, 120);
    dut.Mem[1] = r_t(OP_OR, 3, 3, 3);
    dut.Mem[2] = i_t(OP_LW, 2, 1, 0);
    dut.Mem[3] = r_t(OP_OR, 3, 3, 3);
    dut.Mem[4] = i_t(OP_ADDI, 2, 2, 45);
    dut.Mem[5] = r_t(OP_OR, 4, 4, 4);
    dut.Mem[6] = i_t(OP_SW, 2, 1, 1);
    dut.Mem[7] = i_t(OP_SW, 2, 1, 1);
    dut.Mem[8] = {OP_HLT, 26'd0};
    exp_push("ld_mem120", 1, 120, 32'd85);
    exp_push("ld_mem121", 1, 121, 32'd130);
    exp_push("ld_r1", 0, 1, 32'd120);
    exp_push("ld_r2", 0, 2, 32'd130);
    exp_push("ld_r3", 0, 3, 32'd3);
    exp_push("ld_cycles", 2, 0, 32'd13);
    run("ld");

    // Back-to-back dependents; halt four edges after HLT is fetched
    preload();
    dut.Mem[0] = i_t(OP_ADDI, 1, 0, 10);
    dut.Mem[1] = r_t(OP_ADD, 2, 1, 1);
    dut.Mem[2] = r_t(OP_SUB, 3, 2, 1);
    dut.Mem[3] = {OP_HLT, 26'd0};
    exp_push("dep_r1", 0, 1, 32'd10);
    exp_push("dep_r2", 0, 2, 32'd20);
    exp_push("dep_r3", 0, 3, 32'd10);
    exp_push("dep_cycles", 2, 0, 32'd8);
    run("dep");

    // Loop: three iterations, branch shadow must not write while taken
    preload();
    dut.Mem[0] = i_t(OP_ADDI, 1, 0, 3);
    dut.Mem[1] = i_t(OP_ADDI, 2, 2, 1);
    dut.Mem[2] = i_t(OP_SUBI, 1, 1, 1);
    dut.Mem[3] = i_t(OP_BNEQZ, 0, 1, -3);
    dut.Mem[4] = i_t(OP_ADDI, 3, 3, 1);
    dut.Mem[5] = i_t(OP_ADDI, 4, 4, 1);
    dut.Mem[6] = {OP_HLT, 26'd0};
    exp_push("loop_r1", 0, 1, 32'd0);
    exp_push("loop_r2", 0, 2, 32'd5);
    exp_push("loop_r3", 0, 3, 32'd4);
    exp_push("loop_r4", 0, 4, 32'd5);
    exp_push("loop_cycles", 2, 0, 32'd21);
    run("loop");

    // Signed compares, R0 writes, BEQZ skip, unknown opcode
    preload();
    dut.Reg[5] = 32'hFFFF_FFFF;
    dut.Reg[6] = 32'd1;
    dut.Mem[0]  = r_t(OP_SLT, 7, 5, 6);
    dut.Mem[1]  = i_t(OP_SLTI, 8, 5, -2);
    dut.Mem[2]  = r_t(OP_SLT, 9, 6, 5);
    dut.Mem[3]  = i_t(OP_ADDI, 0, 0, 5);
    dut.Mem[4]  = r_t(OP_ADD, 14, 0, 0);
    dut.Mem[5]  = r_t(OP_AND, 10, 5, 6);
    dut.Mem[6]  = r_t(OP_SUB, 11, 6, 5);
    dut.Mem[7]  = i_t(OP_BEQZ, 0, 0, 1);
    dut.Mem[8]  = i_t(OP_ADDI, 12, 0, 55);
    dut.Mem[9]  = i_t(6'b010000, 13, 0, 5);
    dut.Mem[10] = {OP_HLT, 26'd0};
    exp_push("slt_r7", 0, 7, 32'd1);
    exp_push("slti_r8", 0, 8, 32'd0);
    exp_push("slt_r9", 0, 9, 32'd0);
    exp_push("r0_zero", 0, 0, 32'd0);
    exp_push("r0_read_r14", 0, 14, 32'd0);
    exp_push("and_r10", 0, 10, 32'd1);
    exp_push("sub_r11", 0, 11, 32'd2);
    exp_push("beqz_skip_r12", 0, 12, 32'd12);
    exp_push("nop_r13", 0, 13, 32'd13);
    exp_push("cmp_cycles", 2, 0, 32'd16);
    run("cmp");

    // MUL, result depends on build option
    preload();
    dut.Reg[5] = 32'd6;
    dut.Reg[6] = 32'd7;
    dut.Mem[0] = r_t(OP_MUL, 7, 6, 5);
    dut.Mem[1] = {OP_HLT, 26'd0};
`ifdef PROC_MUL_EN
    exp_push("mul_r7", 0, 7, 32'd42);
`else
    exp_push("mul_r7", 0, 7, 32'd7);
`endif
    exp_push("mul_cycles", 2, 0, 32'd6);
    run("mul");

    // Reset mid-program, then rerun from Mem[0]
    preload();
    dut.Mem[0] = i_t(OP_ADDI, 1, 0, 10);
    dut.Mem[1] = r_t(OP_ADD, 2, 1, 1);
    dut.Mem[2] = r_t(OP_SUB, 3, 2, 1);
    dut.Mem[3] = {OP_HLT, 26'd0};
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_pc_running", dut.PC, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pc", dut.PC, 32'd0);
    chk("mid_rst_halted", {31'b0, halted}, 32'd0);
    exp_push("mid_r2", 0, 2, 32'd20);
    exp_push("mid_r3", 0, 3, 32'd10);
    exp_push("mid_cycles", 2, 0, 32'd8);
    run("mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
